// File: rtl/mcc_pkg.sv
// mcc_pkg: sequencer state encoding and default PC constants
package mcc_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;

    localparam int unsigned MCC_RESET_PC = 0;
    localparam int unsigned MCC_PC_STEP  = 4;

endpackage

// File: rtl/mcc_perf_counters.sv
// mcc_perf_counters: free-running cycle and retired-instruction counters, wrap modulo 2^CNT_W
module mcc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cyc_en,
    input  logic             ret_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // count live cycles and write-back cycles; active-low sync clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (cyc_en) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (ret_en) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mcc_sequencer.sv
// mcc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control with PC and IR; perf counters under MCC_PERF_CNT_EN
module mcc_sequencer import mcc_pkg::*; #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(MCC_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(MCC_PC_STEP),
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] in_mem_addr,
    output logic              in_mem_en,
    input  logic              in_mem_ack,
    input  logic [DATA_W-1:0] in_mem,
    output logic [DATA_W-1:0] instr,
    input  logic              is_mem_op,
    input  logic              is_store,
    input  logic              halt_req,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic              exec_en,
    output logic              data_read,
    output logic              data_write,
    input  logic              data_ack,
    output logic              wb_en,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instr_cnt
);

    state_t            state, state_n;
    logic              mem_q, store_q, br_q;
    logic [ADDR_W-1:0] tgt_q;

    // state register
    always_ff @(posedge clk) state <= !reset ? IDLE : state_n;

    // next-state; HALT is sticky until reset
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = FETCH;
            FETCH:   state_n = in_mem_ack ? DECODE : FETCH;
            DECODE:  state_n = halt_req ? HALT : EXECUTE;
            EXECUTE: state_n = mem_q ? MEM : WB;
            MEM:     state_n = data_ack ? WB : MEM;
            WB:      state_n = FETCH;
            default: state_n = state;
        endcase
    end

    // PC, IR and per-instruction flags captured in the state that owns them
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc      <= RESET_PC;
            instr   <= '0;
            mem_q   <= 1'b0;
            store_q <= 1'b0;
            br_q    <= 1'b0;
            tgt_q   <= '0;
        end else begin
            if (state == FETCH && in_mem_ack) instr <= in_mem;
            if (state == DECODE) begin
                mem_q   <= is_mem_op;
                store_q <= is_store;
            end
            if (state == EXECUTE) begin
                br_q  <= br_taken;
                tgt_q <= br_target;
            end
            if (state == WB) pc <= br_q ? tgt_q : pc + PC_STEP;
        end
    end

    assign in_mem_addr = pc;
    assign in_mem_en   = state == FETCH;
    assign exec_en     = state == EXECUTE;
    assign data_read   = state == MEM && !store_q;
    assign data_write  = state == MEM && store_q;
    assign wb_en       = state == WB;
    assign halted      = state == HALT;

`ifdef MCC_PERF_CNT_EN
    mcc_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .reset     (reset),
        .cyc_en    (state != HALT),
        .ret_en    (state == WB),
        .cycle_cnt (cycle_cnt),
        .instr_cnt (instr_cnt)
    );
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mcc_sequencer.sv
// tb_mcc_sequencer: directed self-checking bench for mcc_sequencer
module tb_mcc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_mem_addr, in_mem, instr, br_target, pc, cycle_cnt, instr_cnt;
    logic        in_mem_en, in_mem_ack, is_mem_op, is_store, halt_req, br_taken;
    logic        exec_en, data_read, data_write, data_ack, wb_en, halted;
    int          n_cmp = 0;
    int          n_fail = 0;

    mcc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .in_mem_addr (in_mem_addr),
        .in_mem_en   (in_mem_en),
        .in_mem_ack  (in_mem_ack),
        .in_mem      (in_mem),
        .instr       (instr),
        .is_mem_op   (is_mem_op),
        .is_store    (is_store),
        .halt_req    (halt_req),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .exec_en     (exec_en),
        .data_read   (data_read),
        .data_write  (data_write),
        .data_ack    (data_ack),
        .wb_en       (wb_en),
        .pc          (pc),
        .halted      (halted),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_mem_ack = 1'b0;
        in_mem = 32'h0;
        is_mem_op = 1'b0;
        is_store = 1'b0;
        halt_req = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        data_ack = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc); end
        n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
        n_cmp++; if ({in_mem_en, exec_en, data_read, data_write, wb_en, halted} !== 6'b0)
            begin n_fail++; $display("FAIL reset_strobes got %b want 000000", {in_mem_en, exec_en, data_read, data_write, wb_en, halted}); end
        n_cmp++; if ({cycle_cnt, instr_cnt} !== 64'h0) begin n_fail++; $display("FAIL reset_cnt got %h/%h want 0/0", cycle_cnt, instr_cnt); end
    endtask

    task automatic test_alu();
        do_reset();
        in_mem_ack = 1'b1;
        in_mem = 32'h1234_5678;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_cmp++; if (in_mem_en !== (c % 4 == 1)) begin n_fail++; $display("FAIL alu_fetch_en c=%0d got %b want %b", c, in_mem_en, c % 4 == 1); end
            if (c % 4 == 1) begin
                n_cmp++; if (in_mem_addr !== 32'(c - 1)) begin n_fail++; $display("FAIL alu_fetch_addr c=%0d got %h want %h", c, in_mem_addr, c - 1); end
            end
            n_cmp++; if (exec_en !== (c % 4 == 3)) begin n_fail++; $display("FAIL alu_exec c=%0d got %b want %b", c, exec_en, c % 4 == 3); end
            n_cmp++; if (wb_en !== (c % 4 == 0)) begin n_fail++; $display("FAIL alu_wb c=%0d got %b want %b", c, wb_en, c % 4 == 0); end
            n_cmp++; if ({data_read, data_write} !== 2'b00) begin n_fail++; $display("FAIL alu_data c=%0d got %b want 00", c, {data_read, data_write}); end
        end
        n_cmp++; if (instr !== 32'h1234_5678) begin n_fail++; $display("FAIL alu_instr got %h want 12345678", instr); end
        step();
        n_cmp++; if (pc !== 32'd12) begin n_fail++; $display("FAIL alu_pc got %h want c", pc); end
`ifdef MCC_PERF_CNT_EN
        n_cmp++; if (instr_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_instr got %0d want 3", instr_cnt); end
        n_cmp++; if (cycle_cnt !== 32'd13) begin n_fail++; $display("FAIL perf_cycle got %0d want 13", cycle_cnt); end
`else
        n_cmp++; if ({cycle_cnt, instr_cnt} !== 64'h0) begin n_fail++; $display("FAIL perf_tied got %h/%h want 0/0", cycle_cnt, instr_cnt); end
`endif
    endtask

    task automatic test_fetch_wait();
        int en_cycles = 0;
        do_reset();
        in_mem = 32'hDEAD_BEEF;
        step();
        for (int i = 0; i < 4; i++) begin
            en_cycles += int'(in_mem_en);
            n_cmp++; if (in_mem_addr !== 32'h0) begin n_fail++; $display("FAIL wait_addr i=%0d got %h want 0", i, in_mem_addr); end
            n_cmp++; if (instr !== 32'h0) begin n_fail++; $display("FAIL wait_instr_early i=%0d got %h want 0", i, instr); end
            if (i == 3) in_mem_ack = 1'b1;
            step();
        end
        in_mem_ack = 1'b0;
        n_cmp++; if (en_cycles !== 4) begin n_fail++; $display("FAIL wait_en_cycles got %0d want 4", en_cycles); end
        n_cmp++; if (in_mem_en !== 1'b0) begin n_fail++; $display("FAIL wait_en_drop got %b want 0", in_mem_en); end
        n_cmp++; if (instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wait_instr got %h want deadbeef", instr); end
    endtask

    task automatic test_mem(input logic st);
        do_reset();
        in_mem_ack = 1'b1;
        is_mem_op = 1'b1;
        is_store = st;
        step();
        step();
        step();
        in_mem_ack = 1'b0;
        n_cmp++; if (exec_en !== 1'b1) begin n_fail++; $display("FAIL mem_exec st=%b got %b want 1", st, exec_en); end
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({data_read, data_write} !== {~st, st})
                begin n_fail++; $display("FAIL mem_req st=%b i=%0d got %b want %b", st, i, {data_read, data_write}, {~st, st}); end
            n_cmp++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL mem_wb_early st=%b i=%0d got %b want 0", st, i, wb_en); end
            if (i == 2) data_ack = 1'b1;
            step();
        end
        data_ack = 1'b0;
        n_cmp++; if ({wb_en, data_read, data_write} !== 3'b100) begin n_fail++; $display("FAIL mem_wb st=%b got %b want 100", st, {wb_en, data_read, data_write}); end
        step();
        n_cmp++; if (in_mem_addr !== 32'd4) begin n_fail++; $display("FAIL mem_next_pc st=%b got %h want 4", st, in_mem_addr); end
    endtask

    task automatic test_branch();
        do_reset();
        in_mem_ack = 1'b1;
        br_taken = 1'b1;
        br_target = 32'h100;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c == 4) begin
                n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL br_pc_hold got %h want 0", pc); end
            end
            if (c == 5) begin
                n_cmp++; if ({in_mem_en, in_mem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL br_target got %b/%h want 1/100", in_mem_en, in_mem_addr); end
                br_target = 32'hFFFF_FFFC;
            end
            if (c == 9) begin
                n_cmp++; if (in_mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL br_top got %h want fffffffc", in_mem_addr); end
                br_taken = 1'b0;
            end
        end
        n_cmp++; if ({in_mem_en, in_mem_addr, pc} !== {1'b1, 64'h0}) begin n_fail++; $display("FAIL pc_wrap got %b/%h/%h want 1/0/0", in_mem_en, in_mem_addr, pc); end
    endtask

    task automatic test_halt();
        do_reset();
        in_mem_ack = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 5) halt_req = 1'b1;
            if (c >= 7) begin
                n_cmp++; if ({halted, in_mem_en, exec_en, wb_en, data_read, data_write} !== 6'b100000)
                    begin n_fail++; $display("FAIL halt_strobes c=%0d got %b want 100000", c, {halted, in_mem_en, exec_en, wb_en, data_read, data_write}); end
                n_cmp++; if (pc !== 32'd4) begin n_fail++; $display("FAIL halt_pc c=%0d got %h want 4", c, pc); end
            end
        end
`ifdef MCC_PERF_CNT_EN
        n_cmp++; if ({cycle_cnt, instr_cnt} !== {32'd7, 32'd1}) begin n_fail++; $display("FAIL halt_cnt got %0d/%0d want 7/1", cycle_cnt, instr_cnt); end
`endif
        halt_req = 1'b0;
        in_mem_ack = 1'b0;
        reset = 1'b0;
        step();
        n_cmp++; if ({halted, pc} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL halt_reset got %b/%h want 0/0", halted, pc); end
        reset = 1'b1;
        step();
        n_cmp++; if ({in_mem_en, in_mem_addr} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL halt_refetch got %b/%h want 1/0", in_mem_en, in_mem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_mem_ack = 1'b1;
        is_mem_op = 1'b1;
        for (int c = 1; c <= 4; c++) step();
        in_mem_ack = 1'b0;
        n_cmp++; if (data_read !== 1'b1) begin n_fail++; $display("FAIL mid_req got %b want 1", data_read); end
        reset = 1'b0;
        step();
        n_cmp++; if ({data_read, in_mem_en} !== 2'b00) begin n_fail++; $display("FAIL mid_drop got %b want 00", {data_read, in_mem_en}); end
        reset = 1'b1;
        data_ack = 1'b1;
        step();
        n_cmp++; if ({in_mem_en, in_mem_addr, data_read} !== {1'b1, 32'h0, 1'b0}) begin n_fail++; $display("FAIL mid_fetch got %b/%h/%b want 1/0/0", in_mem_en, in_mem_addr, data_read); end
        step();
        n_cmp++; if ({in_mem_en, wb_en, data_read} !== 3'b100) begin n_fail++; $display("FAIL mid_late_ack got %b want 100", {in_mem_en, wb_en, data_read}); end
        data_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_fetch_wait();
        test_mem(1'b0);
        test_mem(1'b1);
        test_branch();
        test_halt();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
